aes256_cbc_framer: RTL and testbench

- Upstream framing stage for aes256_cbc_iter.
- Takes a per-message configuration (key, IV, direction) and a byte-oriented payload AXI-Stream.
- Emits the exact beat sequence the CBC core consumes: 4 key beats, 2 IV beats, then 128-bit text blocks as 64-bit beats.
- Encrypt direction: appends PKCS#7 padding so the payload always ends on a 16-byte block boundary.

---
 rtl/aes256_cbc_framer.sv | 208 ++++++++++++++++++++
 tb/tb_aes256_cbc_framer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_cbc_framer.sv
// Framing stage ahead of the AES-256 CBC core: emits key beats, IV beats, then the payload
// as whole 128-bit blocks (PKCS#7 padded on encrypt, zero-filled and flagged on decrypt).
module aes256_cbc_framer #(
  parameter int unsigned AXIS_WIDTH  = 64,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Cfg_valid,
  output logic                    Cfg_ready,
  input  logic [255:0]            Cfg_key,
  input  logic [127:0]            Cfg_iv,
  input  logic                    Cfg_encrypt,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
  input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
  input  logic                    S_axis_tlast,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                    M_axis_tlast,
  output logic                    M_axis_tuser,
  output logic                    Error
);

  localparam int unsigned Lanes       = AXIS_WIDTH / 8;
  localparam logic [4:0]  BlockBytesW = 5'(BLOCK_BYTES);

  if (AXIS_WIDTH != 64 || BLOCK_BYTES != 16) begin : gen_param_check
    $error("aes256_cbc_framer supports only AXIS_WIDTH=64 and BLOCK_BYTES=16");
  end

  typedef enum logic [2:0] {StIdle, StKey, StIv, StData, StPad} state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           p_q, p_d;
  logic           err_q, err_d;
  logic           enc_q, enc_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   iv_q, iv_d;
  logic [7:0]     pad_byte_q, pad_byte_d;
  logic           live_q;

  // Last-beat shaping: byte count, pad value and how many extra beats finish the block.
  logic [3:0]            n_bytes;
  logic                  last_full;
  logic [4:0]            fill_cnt;
  logic [4:0]            pad_cnt;
  logic [7:0]            fill_byte;
  logic [AXIS_WIDTH-1:0] last_data;
  logic [1:0]            pad_beats;

  always_comb begin
    n_bytes = '0;
    for (int i = 0; i < Lanes; i++) begin
      n_bytes = n_bytes + 4'(S_axis_tkeep[i]);
    end
    last_full = (n_bytes == 4'd8);
    fill_cnt  = (p_q ? 5'd8 : 5'd0) + 5'(n_bytes);
    pad_cnt   = BlockBytesW - fill_cnt;
    if (pad_cnt == 5'd0) begin
      pad_cnt = BlockBytesW;
    end
    fill_byte = enc_q ? {3'b000, pad_cnt} : 8'h00;
    for (int i = 0; i < Lanes; i++) begin
      last_data[8*i +: 8] = (4'(i) < n_bytes) ? S_axis_tdata[8*i +: 8] : fill_byte;
    end
    // A first-half last beat always needs one more beat; a full second half needs a whole
    // extra block only when padding.
    if (!p_q) begin
      pad_beats = 2'd1;
    end else if (enc_q && last_full) begin
      pad_beats = 2'd2;
    end else begin
      pad_beats = 2'd0;
    end
  end

  logic                  m_valid;
  logic [AXIS_WIDTH-1:0] m_data;
  logic                  m_last;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_d           = p_q;
    err_d         = err_q;
    enc_d         = enc_q;
    key_d         = key_q;
    iv_d          = iv_q;
    pad_byte_d    = pad_byte_q;
    Cfg_ready     = 1'b0;
    S_axis_tready = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    m_last        = 1'b0;

    unique case (state_q)
      StIdle: begin
        Cfg_ready = live_q;
        if (Cfg_valid && live_q) begin
          key_d   = Cfg_key;
          iv_d    = Cfg_iv;
          enc_d   = Cfg_encrypt;
          err_d   = 1'b0;
          cnt_d   = 2'd0;
          p_d     = 1'b0;
          state_d = StKey;
        end
      end
      StKey: begin
        m_valid = 1'b1;
        m_data  = key_q[{cnt_q, 6'b0} +: AXIS_WIDTH];
        if (M_axis_tready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StIv;
          end
        end
      end
      StIv: begin
        m_valid = 1'b1;
        m_data  = iv_q[{cnt_q[0], 6'b0} +: AXIS_WIDTH];
        if (M_axis_tready) begin
          if (cnt_q[0]) begin
            cnt_d   = 2'd0;
            state_d = StData;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      StData: begin
        S_axis_tready = M_axis_tready;
        m_valid       = S_axis_tvalid;
        if (S_axis_tlast) begin
          m_data = last_data;
          m_last = (pad_beats == 2'd0);
        end else begin
          m_data = S_axis_tdata;
        end
        if (S_axis_tvalid && M_axis_tready) begin
          p_d = ~p_q;
          if (S_axis_tlast) begin
            pad_byte_d = fill_byte;
            if (!enc_q && !(p_q && last_full)) begin
              err_d = 1'b1;
            end
            if (pad_beats == 2'd0) begin
              state_d = StIdle;
            end else begin
              cnt_d   = pad_beats;
              state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        m_valid = 1'b1;
        m_data  = {Lanes{pad_byte_q}};
        m_last  = (cnt_q == 2'd1);
        if (M_axis_tready) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced to zero whenever no beat is offered so idle/reset values are clean.
  assign M_axis_tvalid = m_valid;
  assign M_axis_tdata  = m_valid ? m_data : '0;
  assign M_axis_tkeep  = m_valid ? '1 : '0;
  assign M_axis_tlast  = m_valid & m_last;
  assign M_axis_tuser  = m_valid & enc_q;
  assign Error         = err_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      p_q        <= 1'b0;
      err_q      <= 1'b0;
      enc_q      <= 1'b0;
      key_q      <= '0;
      iv_q       <= '0;
      pad_byte_q <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      err_q      <= err_d;
      enc_q      <= enc_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      pad_byte_q <= pad_byte_d;
      live_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes256_cbc_framer.sv
// Self-checking bench for aes256_cbc_framer: directed vector table, reset corner cases and
// randomized messages with backpressure checked against a byte-level framing model.
module tb_aes256_cbc_framer;

  logic         Clk;
  logic         Rst_n;
  logic         Cfg_valid;
  logic         Cfg_ready;
  logic [255:0] Cfg_key;
  logic [127:0] Cfg_iv;
  logic         Cfg_encrypt;
  logic         S_axis_tvalid;
  logic         S_axis_tready;
  logic [63:0]  S_axis_tdata;
  logic [7:0]   S_axis_tkeep;
  logic         S_axis_tlast;
  logic         M_axis_tvalid;
  logic         M_axis_tready;
  logic [63:0]  M_axis_tdata;
  logic [7:0]   M_axis_tkeep;
  logic         M_axis_tlast;
  logic         M_axis_tuser;
  logic         Error;

  aes256_cbc_framer #(.AXIS_WIDTH(64), .BLOCK_BYTES(16)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Cfg_valid     (Cfg_valid),
    .Cfg_ready     (Cfg_ready),
    .Cfg_key       (Cfg_key),
    .Cfg_iv        (Cfg_iv),
    .Cfg_encrypt   (Cfg_encrypt),
    .S_axis_tvalid (S_axis_tvalid),
    .S_axis_tready (S_axis_tready),
    .S_axis_tdata  (S_axis_tdata),
    .S_axis_tkeep  (S_axis_tkeep),
    .S_axis_tlast  (S_axis_tlast),
    .M_axis_tvalid (M_axis_tvalid),
    .M_axis_tready (M_axis_tready),
    .M_axis_tdata  (M_axis_tdata),
    .M_axis_tkeep  (M_axis_tkeep),
    .M_axis_tlast  (M_axis_tlast),
    .M_axis_tuser  (M_axis_tuser),
    .Error         (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    bit          enc;
    int          len;
    bit          add_empty;
    int          exp_beats;
    logic [63:0] exp_last;
    bit          exp_err;
  } vec_t;

  vec_t vecs[13];

  // Reference model output for the current message.
  logic [63:0] exp_data[$];
  bit          exp_last_q[$];
  bit          exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Byte-level model: key words, IV words, then the payload as whole 16-byte blocks.
  function automatic void build_model(input logic [255:0] key, input logic [127:0] iv,
                                      input bit enc, input int nbeats, input bq_t pay);
    bq_t txt;
    int  len;
    int  padv;
    int  tot;
    logic [63:0] w;
    txt = pay;
    len = pay.size();
    exp_data.delete();
    exp_last_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_data.push_back(key[64*k +: 64]);
      exp_last_q.push_back(1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      exp_data.push_back(iv[64*k +: 64]);
      exp_last_q.push_back(1'b0);
    end
    if (enc) begin
      padv = 16 - (len % 16);
      for (int k = 0; k < padv; k++) txt.push_back(8'(padv));
      exp_err = 1'b0;
    end else begin
      tot = ((nbeats * 8 + 15) / 16) * 16;
      while (txt.size() < tot) txt.push_back(8'h00);
      exp_err = !((nbeats % 2 == 0) && (len == nbeats * 8));
    end
    for (int b = 0; b < txt.size() / 8; b++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = txt[8*b + j];
      exp_data.push_back(w);
      exp_last_q.push_back(b == txt.size() / 8 - 1);
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 64'(Cfg_ready), 64'd0);
    chk({tag, "_s_tready"}, 64'(S_axis_tready), 64'd0);
    chk({tag, "_m_tvalid"}, 64'(M_axis_tvalid), 64'd0);
    chk({tag, "_m_tdata"}, M_axis_tdata, 64'd0);
    chk({tag, "_m_tkeep"}, 64'(M_axis_tkeep), 64'd0);
    chk({tag, "_m_tlast"}, 64'(M_axis_tlast), 64'd0);
    chk({tag, "_m_tuser"}, 64'(M_axis_tuser), 64'd0);
    chk({tag, "_error"}, 64'(Error), 64'd0);
  endtask

  task automatic run_msg(input logic [255:0] key, input logic [127:0] iv, input bit enc,
                         input int len, input bit add_empty, input bit rnd, input bit stall,
                         input int abort_after, output int n_out, output logic [63:0] last_out,
                         output logic err_out);
    bq_t         pay;
    logic [63:0] in_data[$];
    logic [7:0]  in_keep[$];
    logic [63:0] w;
    logic [63:0] held_data;
    logic        held_last;
    logic        held_user;
    int          nb, cnt, in_idx, out_idx, cyc;
    bit          cfg_done, prev_stall, cfg_fire, s_fire;

    for (int i = 0; i < len; i++) pay.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    nb = (len == 0) ? 1 : (len + 7) / 8;
    if (add_empty && len > 0 && len % 8 == 0) nb++;
    for (int b = 0; b < nb; b++) begin
      w   = '0;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < len) begin
          w[8*j +: 8] = pay[8*b + j];
          cnt++;
        end
      end
      in_data.push_back(w);
      in_keep.push_back(8'((16'd1 << cnt) - 16'd1));
    end
    build_model(key, iv, enc, nb, pay);

    n_out      = 0;
    last_out   = '0;
    err_out    = 1'b0;
    in_idx     = 0;
    out_idx    = 0;
    cyc        = 0;
    cfg_done   = 1'b0;
    prev_stall = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    held_user  = 1'b0;

    @(posedge Clk); #1;
    Cfg_valid     = 1'b1;
    Cfg_key       = key;
    Cfg_iv        = iv;
    Cfg_encrypt   = enc;
    S_axis_tvalid = 1'b0;
    M_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;

    while (out_idx < exp_data.size() && cyc < 3000) begin
      cyc++;
      @(negedge Clk);
      if (prev_stall) begin
        chk("stall_valid", 64'(M_axis_tvalid), 64'd1);
        chk("stall_data", M_axis_tdata, held_data);
        chk("stall_last", 64'(M_axis_tlast), 64'(held_last));
        chk("stall_user", 64'(M_axis_tuser), 64'(held_user));
      end
      if (M_axis_tvalid && out_idx == 0) chk("error_cleared", 64'(Error), 64'd0);
      if (in_idx == nb) chk("s_tready_after_last", 64'(S_axis_tready), 64'd0);
      cfg_fire = Cfg_valid && Cfg_ready;
      s_fire   = S_axis_tvalid && S_axis_tready;
      if (M_axis_tvalid && M_axis_tready) begin
        chk($sformatf("beat%0d_data", out_idx), M_axis_tdata, exp_data[out_idx]);
        chk($sformatf("beat%0d_last", out_idx), 64'(M_axis_tlast), 64'(exp_last_q[out_idx]));
        chk($sformatf("beat%0d_user", out_idx), 64'(M_axis_tuser), 64'(enc));
        chk($sformatf("beat%0d_keep", out_idx), 64'(M_axis_tkeep), 64'hFF);
        last_out = M_axis_tdata;
        out_idx++;
        n_out = out_idx;
      end
      prev_stall = M_axis_tvalid && !M_axis_tready;
      held_data  = M_axis_tdata;
      held_last  = M_axis_tlast;
      held_user  = M_axis_tuser;
      if (abort_after != 0 && out_idx == abort_after) break;
      @(posedge Clk); #1;
      if (cfg_fire) begin
        Cfg_valid = 1'b0;
        cfg_done  = 1'b1;
      end
      if (s_fire) begin
        in_idx++;
        S_axis_tvalid = 1'b0;
      end
      if (cfg_done && in_idx < nb && !S_axis_tvalid && (!stall || $urandom_range(0, 3) != 0))
      begin
        S_axis_tvalid = 1'b1;
        S_axis_tdata  = in_data[in_idx];
        S_axis_tkeep  = in_keep[in_idx];
        S_axis_tlast  = (in_idx == nb - 1);
      end
      M_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    if (abort_after == 0) begin
      if (out_idx < exp_data.size()) chk("beat_count_timeout", 64'(out_idx),
                                         64'(exp_data.size()));
      @(posedge Clk); #1;
      Cfg_valid     = 1'b0;
      S_axis_tvalid = 1'b0;
      M_axis_tready = 1'b1;
      @(negedge Clk);
      err_out = Error;
      chk("end_error", 64'(Error), 64'(exp_err));
      chk("end_m_tvalid", 64'(M_axis_tvalid), 64'd0);
      chk("end_cfg_ready", 64'(Cfg_ready), 64'd1);
    end
  endtask

  task automatic do_reset_pulse(input string tag);
    #2;
    Rst_n         = 1'b0;
    Cfg_valid     = 1'b0;
    S_axis_tvalid = 1'b0;
    M_axis_tready = 1'b1;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge Clk);
    #2;
    Rst_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk({tag, "_cfg_ready_after"}, 64'(Cfg_ready), 64'd1);
  endtask

  logic [255:0] tkey;
  logic [127:0] tiv;
  logic [255:0] rkey;
  logic [127:0] riv;
  int           n_out;
  logic [63:0]  last_out;
  logic         err_out;

  initial begin
    vecs[0]  = '{1'b1, 16, 1'b0, 10, 64'h1010101010101010, 1'b0};
    vecs[1]  = '{1'b1,  5, 1'b0,  8, 64'h0B0B0B0B0B0B0B0B, 1'b0};
    vecs[2]  = '{1'b1, 13, 1'b0,  8, 64'h0303030D0C0B0A09, 1'b0};
    vecs[3]  = '{1'b1,  0, 1'b0,  8, 64'h1010101010101010, 1'b0};
    vecs[4]  = '{1'b1,  8, 1'b0,  8, 64'h0808080808080808, 1'b0};
    vecs[5]  = '{1'b1, 15, 1'b0,  8, 64'h010F0E0D0C0B0A09, 1'b0};
    vecs[6]  = '{1'b1, 24, 1'b0, 10, 64'h0808080808080808, 1'b0};
    vecs[7]  = '{1'b1, 16, 1'b1, 10, 64'h1010101010101010, 1'b0};
    vecs[8]  = '{1'b1,  8, 1'b1,  8, 64'h0808080808080808, 1'b0};
    vecs[9]  = '{1'b0, 32, 1'b0, 10, 64'h201F1E1D1C1B1A19, 1'b0};
    vecs[10] = '{1'b0, 12, 1'b0,  8, 64'h000000000C0B0A09, 1'b1};
    vecs[11] = '{1'b0,  5, 1'b0,  8, 64'h0000000000000000, 1'b1};
    vecs[12] = '{1'b0, 16, 1'b1, 10, 64'h0000000000000000, 1'b1};

    for (int i = 0; i < 32; i++) tkey[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) tiv[8*i +: 8] = 8'(8'hA0 + i);

    Rst_n         = 1'b0;
    Cfg_valid     = 1'b0;
    Cfg_key       = '0;
    Cfg_iv        = '0;
    Cfg_encrypt   = 1'b0;
    S_axis_tvalid = 1'b0;
    S_axis_tdata  = '0;
    S_axis_tkeep  = '0;
    S_axis_tlast  = 1'b0;
    M_axis_tready = 1'b0;
    #23;
    check_reset_outputs("por");
    Rst_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("por_cfg_ready_after", 64'(Cfg_ready), 64'd1);
    chk("first_key_word_model", exp_data.size() == 0 ? 64'd0 : 64'd1, 64'd0);

    for (int v = 0; v < 13; v++) begin
      run_msg(tkey, tiv, vecs[v].enc, vecs[v].len, vecs[v].add_empty, 1'b0, 1'b0, 0,
              n_out, last_out, err_out);
      chk($sformatf("vec%0d_beats", v), 64'(n_out), 64'(vecs[v].exp_beats));
      chk($sformatf("vec%0d_last_data", v), last_out, vecs[v].exp_last);
      chk($sformatf("vec%0d_error", v), 64'(err_out), 64'(vecs[v].exp_err));
    end

    // Error stays set while idle and clears on the next configuration accept.
    run_msg(tkey, tiv, 1'b0, 12, 1'b0, 1'b0, 1'b0, 0, n_out, last_out, err_out);
    repeat (3) begin
      @(negedge Clk);
      chk("error_sticky_idle", 64'(Error), 64'd1);
    end
    run_msg(tkey, tiv, 1'b1, 5, 1'b0, 1'b0, 1'b0, 0, n_out, last_out, err_out);
    chk("error_after_new_cfg", 64'(err_out), 64'd0);

    // Reset after three key beats, then a clean message from key word 0.
    run_msg(tkey, tiv, 1'b1, 16, 1'b0, 1'b0, 1'b0, 3, n_out, last_out, err_out);
    do_reset_pulse("rst_key");
    run_msg(tkey, tiv, 1'b1, 16, 1'b0, 1'b0, 1'b0, 0, n_out, last_out, err_out);
    chk("rst_key_next_beats", 64'(n_out), 64'd10);

    // Reset mid-payload.
    run_msg(tkey, tiv, 1'b0, 32, 1'b0, 1'b0, 1'b0, 8, n_out, last_out, err_out);
    do_reset_pulse("rst_data");
    run_msg(tkey, tiv, 1'b1, 13, 1'b0, 1'b0, 1'b0, 0, n_out, last_out, err_out);
    chk("rst_data_next_last", last_out, 64'h0303030D0C0B0A09);

    // Randomized messages under random backpressure and source gaps.
    for (int m = 0; m < 30; m++) begin
      int  len;
      bit  enc;
      bit  add_empty;
      for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom;
      for (int w = 0; w < 4; w++) riv[32*w +: 32] = $urandom;
      len       = $urandom_range(0, 40);
      enc       = 1'($urandom_range(0, 1));
      add_empty = 1'($urandom_range(0, 1));
      run_msg(rkey, riv, enc, len, add_empty, 1'b1, 1'b1, 0, n_out, last_out, err_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
